// File: rtl/quokka_panel_pkg.sv
// Shared types for the front-panel command scheduler:
// command/status/state encodings and command-class predicates.
package quokka_panel_pkg;

    typedef enum logic [3:0] {
        CMD_NOP      = 4'd0,
        CMD_STEP     = 4'd1,
        CMD_RUNHALT  = 4'd2,
        CMD_RESET    = 4'd3,
        CMD_STOREINC = 4'd4,
        CMD_DEC      = 4'd5,
        CMD_LOAD     = 4'd6,
        CMD_IRQ      = 4'd7,
        CMD_TOA      = 4'd8,
        CMD_TOX      = 4'd9,
        CMD_TOY      = 4'd10,
        CMD_TOPC     = 4'd11,
        CMD_TOSP     = 4'd12
    } cmd_e;

    typedef enum logic [1:0] {
        ST_OK          = 2'd0,
        ST_REJ_RUNNING = 2'd1,
        ST_REJ_ILLEGAL = 2'd2,
        ST_TIMEOUT     = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_STEP_LEAVE,
        S_STEP_RETURN,
        S_DONE
    } state_e;

    // Codes 13..15 have no meaning.
    function automatic logic is_legal(logic [3:0] c);
        return c <= 4'd12;
    endfunction

    // Commands that only make sense while the CPU sits in the monitor.
    function automatic logic is_stop_gated(logic [3:0] c);
        case (c)
            CMD_STEP, CMD_RESET, CMD_STOREINC, CMD_DEC, CMD_LOAD,
            CMD_TOA, CMD_TOX, CMD_TOY, CMD_TOPC, CMD_TOSP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Commands whose strobe carries the 16-bit operand.
    function automatic logic is_data_cmd(logic [3:0] c);
        case (c)
            CMD_STOREINC, CMD_LOAD, CMD_TOA, CMD_TOX,
            CMD_TOY, CMD_TOPC, CMD_TOSP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/panel_cmd_sched_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = panel, bit 1 = host.
// The tie-break pointer flips after every grant and resets to the panel.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    // Lone requester wins; the pointer only breaks ties.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            gnt_o[0] = req_i[0] & (~req_i[1] | ~ptr_q);
            gnt_o[1] = req_i[1] & (~req_i[0] | ptr_q);
        end
    end

    // Flip the tie-break pointer on every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (|gnt_o) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/panel_cmd_sched.sv
// Front-panel command scheduler: arbitrates panel/host commands into CPU strobes.
// Optional STEP completion timeout is built when PANEL_CMD_TIMEOUT_EN is defined.
module panel_cmd_sched
    import quokka_panel_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_valid,
    input  logic        h_valid,
    output logic        p_ready,
    output logic        h_ready,
    input  logic [3:0]  p_cmd,
    input  logic [3:0]  h_cmd,
    input  logic [15:0] p_data,
    input  logic [15:0] h_data,
    output logic        p_done,
    output logic        h_done,
    output logic [1:0]  p_status,
    output logic [1:0]  h_status,
    input  logic        stopped,
    output logic        b_step,
    output logic        b_reset,
    output logic        b_runhalt,
    output logic        b_storeinc,
    output logic        b_irq,
    output logic        b_dec,
    output logic        b_load,
    output logic        b_toA,
    output logic        b_toSP,
    output logic        b_toX,
    output logic        b_toY,
    output logic        b_toPC,
    output logic [15:0] userInput,
    output logic        inputValid,
    output logic        busy
);

    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    if (HOLDOFF < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("panel_cmd_sched: HOLDOFF and TIMEOUT must be >= 1");
    end

    state_e        state_q;
    status_e       status_q;
    logic [3:0]    cmd_q;
    logic [15:0]   data_q;
    logic [15:0]   uin_q;
    logic          own_q;
    logic [HW-1:0] hcnt_q;

`ifdef PANEL_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt_q;
    logic          t_exp;
    assign t_exp = (tcnt_q == T_LAST);
`endif

    logic       idle;
    logic       issue;
    logic       rej_ill;
    logic       rej_run;
    logic       fire;
    logic       dn;
    logic [1:0] gnt;

    assign idle    = (state_q == S_IDLE) & ~rst;
    assign issue   = (state_q == S_ISSUE) & ~rst;
    assign rej_ill = ~is_legal(cmd_q);
    assign rej_run = ~rej_ill & is_stop_gated(cmd_q) & ~stopped;
    assign fire    = issue & ~rej_ill & ~rej_run & (cmd_q != CMD_NOP);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (idle),
        .req_i ({h_valid, p_valid}),
        .gnt_o (gnt)
    );

    assign p_ready    = gnt[0];
    assign h_ready    = gnt[1];
    assign dn         = (state_q == S_DONE) & ~rst;
    assign p_done     = dn & ~own_q;
    assign h_done     = dn & own_q;
    assign p_status   = p_done ? status_q : ST_OK;
    assign h_status   = h_done ? status_q : ST_OK;
    assign busy       = (state_q != S_IDLE);
    assign inputValid = fire & is_data_cmd(cmd_q);
    assign userInput  = issue ? data_q : uin_q;

    // One-hot strobe decode, only during an accepted ISSUE cycle.
    always_comb begin
        {b_step, b_reset, b_runhalt, b_storeinc, b_irq, b_dec,
         b_load, b_toA, b_toSP, b_toX, b_toY, b_toPC} = '0;
        if (fire) begin
            case (cmd_q)
                CMD_STEP:     b_step     = 1'b1;
                CMD_RESET:    b_reset    = 1'b1;
                CMD_RUNHALT:  b_runhalt  = 1'b1;
                CMD_STOREINC: b_storeinc = 1'b1;
                CMD_IRQ:      b_irq      = 1'b1;
                CMD_DEC:      b_dec      = 1'b1;
                CMD_LOAD:     b_load     = 1'b1;
                CMD_TOA:      b_toA      = 1'b1;
                CMD_TOSP:     b_toSP     = 1'b1;
                CMD_TOX:      b_toX      = 1'b1;
                CMD_TOY:      b_toY      = 1'b1;
                CMD_TOPC:     b_toPC     = 1'b1;
                default:      ;
            endcase
        end
    end

    // Command sequencer: accept, issue, settle, optional STEP wait, done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            cmd_q    <= '0;
            data_q   <= '0;
            uin_q    <= '0;
            own_q    <= 1'b0;
            hcnt_q   <= '0;
`ifdef PANEL_CMD_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|gnt) begin
                        cmd_q   <= gnt[1] ? h_cmd : p_cmd;
                        data_q  <= gnt[1] ? h_data : p_data;
                        own_q   <= gnt[1];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    uin_q  <= data_q;
                    hcnt_q <= '0;
                    if (rej_ill) begin
                        status_q <= ST_REJ_ILLEGAL;
                        state_q  <= S_DONE;
                    end else if (rej_run) begin
                        status_q <= ST_REJ_RUNNING;
                        state_q  <= S_DONE;
                    end else begin
                        status_q <= ST_OK;
                        state_q  <= (cmd_q == CMD_NOP) ? S_DONE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_q <= (cmd_q == CMD_STEP) ? S_STEP_LEAVE : S_DONE;
`ifdef PANEL_CMD_TIMEOUT_EN
                        tcnt_q  <= '0;
`endif
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                S_STEP_LEAVE: begin
`ifdef PANEL_CMD_TIMEOUT_EN
                    tcnt_q <= tcnt_q + 1'b1;
                    if (t_exp) begin
                        status_q <= ST_TIMEOUT;
                        state_q  <= S_DONE;
                    end else if (!stopped) begin
                        state_q <= S_STEP_RETURN;
                    end
`else
                    if (!stopped) begin
                        state_q <= S_STEP_RETURN;
                    end
`endif
                end
                S_STEP_RETURN: begin
`ifdef PANEL_CMD_TIMEOUT_EN
                    tcnt_q <= tcnt_q + 1'b1;
                    if (stopped) begin
                        state_q <= S_DONE;
                    end else if (t_exp) begin
                        status_q <= ST_TIMEOUT;
                        state_q  <= S_DONE;
                    end
`else
                    if (stopped) begin
                        state_q <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panel_cmd_sched.sv
// Scoreboard bench for panel_cmd_sched (HOLDOFF=4, TIMEOUT=100).
// Expected strobes and done responses are queued at accept and popped as the DUT emits them.
module tb_panel_cmd_sched;

    localparam int HO = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p_valid = 1'b0, h_valid = 1'b0;
    logic        p_ready, h_ready;
    logic [3:0]  p_cmd = '0, h_cmd = '0;
    logic [15:0] p_data = '0, h_data = '0;
    logic        p_done, h_done;
    logic [1:0]  p_status, h_status;
    logic        stopped = 1'b1;
    logic        b_step, b_reset, b_runhalt, b_storeinc, b_irq, b_dec;
    logic        b_load, b_toA, b_toSP, b_toX, b_toY, b_toPC;
    logic [15:0] userInput;
    logic        inputValid, busy;

    panel_cmd_sched #(.HOLDOFF(HO), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .h_valid(h_valid),
        .p_ready(p_ready), .h_ready(h_ready),
        .p_cmd(p_cmd), .h_cmd(h_cmd),
        .p_data(p_data), .h_data(h_data),
        .p_done(p_done), .h_done(h_done),
        .p_status(p_status), .h_status(h_status),
        .stopped(stopped),
        .b_step(b_step), .b_reset(b_reset), .b_runhalt(b_runhalt),
        .b_storeinc(b_storeinc), .b_irq(b_irq), .b_dec(b_dec),
        .b_load(b_load), .b_toA(b_toA), .b_toSP(b_toSP),
        .b_toX(b_toX), .b_toY(b_toY), .b_toPC(b_toPC),
        .userInput(userInput), .inputValid(inputValid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stb   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [11:0] stb;
    assign stb = {b_toPC, b_toY, b_toX, b_toSP, b_toA, b_load,
                  b_dec, b_irq, b_storeinc, b_runhalt, b_reset, b_step};

    logic [37:0] all_o;
    assign all_o = {p_ready, h_ready, p_done, h_done, p_status, h_status,
                    stb, userInput, inputValid, busy};

    typedef struct {
        bit host;
        int st;
        int cyc;
    } done_t;

    typedef struct {
        logic [11:0] vec;
        bit          iv;
        logic [15:0] data;
        int          cyc;
    } stb_t;

    done_t dq[$];
    stb_t  sq[$];
    done_t de;
    stb_t  se;

    function automatic logic [11:0] onehot(input int c);
        logic [11:0] v;
        v = '0;
        case (c)
            1:  v[0]  = 1'b1;
            2:  v[2]  = 1'b1;
            3:  v[1]  = 1'b1;
            4:  v[3]  = 1'b1;
            5:  v[5]  = 1'b1;
            6:  v[6]  = 1'b1;
            7:  v[4]  = 1'b1;
            8:  v[7]  = 1'b1;
            9:  v[9]  = 1'b1;
            10: v[10] = 1'b1;
            11: v[11] = 1'b1;
            12: v[8]  = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    // Output monitor: pops expectations as strobes/done pulses appear.
    always @(negedge clk) begin
        if (stb != 12'd0) begin
            n_stb++;
            check("stb_onehot", 64'($countones(stb)), 64'd1);
            if (sq.size() == 0) begin
                check("stb_unexpected", 64'(stb), 64'd0);
            end else begin
                se = sq.pop_front();
                check("stb_vec", 64'(stb), 64'(se.vec));
                check("stb_cyc", 64'(cyc), 64'(se.cyc));
                check("stb_iv", 64'(inputValid), 64'(se.iv));
                check("stb_data", 64'(userInput), 64'(se.data));
            end
        end else if (inputValid) begin
            check("iv_stray", 64'd1, 64'd0);
        end
        if (p_done || h_done) begin
            if (p_done && h_done) check("done_both", 64'd1, 64'd0);
            if (p_ready || h_ready) check("done_with_ready", 64'd1, 64'd0);
            if (dq.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                de = dq.pop_front();
                check("done_who", 64'(h_done), 64'(de.host));
                check("done_status", 64'(h_done ? h_status : p_status), 64'(de.st));
                check("done_cyc", 64'(cyc), 64'(de.cyc));
            end
        end
    end

    task automatic send(input bit host, input int cmd, input int data,
                        input bit push, input int extra, input int st_ovr,
                        output int n);
        bit ok;
        bit gated;
        int st;
        logic [11:0] v;
        @(negedge clk);
        if (host) begin
            h_valid = 1'b1; h_cmd = cmd[3:0]; h_data = data[15:0];
        end else begin
            p_valid = 1'b1; p_cmd = cmd[3:0]; p_data = data[15:0];
        end
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (host ? h_ready : p_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n = cyc;
        check("accept", 64'(ok), 64'd1);
        gated = cmd inside {1, 3, 4, 5, 6, 8, 9, 10, 11, 12};
        st = (cmd > 12) ? 2 : ((gated && !stopped) ? 1 : 0);
        v = (st == 0) ? onehot(cmd) : 12'd0;
        if (ok && v != 12'd0)
            sq.push_back('{v, (cmd inside {4, 6, 8, 9, 10, 11, 12}), data[15:0], n + 1});
        if (ok && push)
            dq.push_back('{host, (st_ovr >= 0) ? st_ovr : st,
                           n + ((v != 12'd0) ? 2 + HO : 2) + extra});
        @(negedge clk);
        if (host) h_valid = 1'b0;
        else      p_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (dq.size() == 0 && sq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // CPU model: leave the monitor 2 cycles after b_step, return rise_after later.
    task automatic cpu_model(input int rise_after);
        int s;
        bit seen;
        seen = 1'b0;
        s = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b_step) begin
                seen = 1'b1;
                s = cyc;
                break;
            end
        end
        check("step_strobe_seen", 64'(seen), 64'd1);
        if (seen) begin
            while (cyc < s + 2) @(negedge clk);
            stopped = 1'b0;
            if (rise_after > 0) begin
                while (cyc < s + 2 + rise_after) @(negedge clk);
                stopped = 1'b1;
            end
        end
    endtask

    int n, np, nh, s0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs_in_rst", 64'(all_o), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_outs", 64'(all_o), 64'd0);

        // LOAD from panel while stopped
        stopped = 1'b1;
        send(0, 6, 'h1234, 1, 0, -1, n);
        wait_idle();
        check("uin_hold", 64'(userInput), 64'h1234);

        // TOA from host while running: rejected
        stopped = 1'b0;
        send(1, 8, 'hBEEF, 1, 0, -1, n);
        wait_idle();

        // both requesting from reset
        stopped = 1'b1;
        do_reset();
        s0 = n_stb;
        fork
            send(0, 4, 'h00AA, 1, 0, -1, np);
            send(1, 7, 'h0000, 1, 0, -1, nh);
        join
        check("rr_panel_first", 64'(np < nh), 64'd1);
        wait_idle();
        check("rr_two_strobes", 64'(n_stb - s0), 64'd2);
        fork
            send(0, 0, 0, 1, 0, -1, np);
            send(1, 0, 0, 1, 0, -1, nh);
        join
        check("rr_ptr_back", 64'(np < nh), 64'd1);
        wait_idle();

        // STEP with normal completion
        stopped = 1'b1;
        fork
            send(0, 1, 0, 1, 28, -1, n);
            cpu_model(30);
        join
        wait_idle();

        // STEP where the CPU never returns
        stopped = 1'b1;
`ifdef PANEL_CMD_TIMEOUT_EN
        fork
            send(1, 1, 0, 1, TO, 3, n);
            cpu_model(0);
        join
        wait_idle();
`else
        fork
            send(1, 1, 0, 0, 0, -1, n);
            cpu_model(0);
        join
        repeat (250) @(negedge clk);
        check("step_waits_busy", 64'(busy), 64'd1);
`endif
        stopped = 1'b1;
        do_reset();
        #1;
        check("busy_after_reset", 64'(busy), 64'd0);

        // reset during HOLD: no done pulse
        send(0, 5, 'h0055, 0, 0, -1, n);
        while (cyc < n + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_hold_outs", 64'(all_o), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // illegal code, running-legal RUNHALT, NOP
        send(1, 14, 'h0007, 1, 0, -1, n);
        wait_idle();
        stopped = 1'b0;
        send(0, 2, 'h0001, 1, 0, -1, n);
        wait_idle();
        send(1, 0, 'h0002, 1, 0, -1, n);
        wait_idle();

        check("sb_empty", 64'(dq.size() + sq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/panel_cmd_sched.md
# panel_cmd_sched

Front-panel command scheduler between two command sources (physical keypad decoder and UART host link) and the CPU-control block's one-cycle button/strobe inputs. Round-robin arbitration grants one command at a time. The granted command is checked against the CPU run/stop state, issued as a single-cycle strobe with optional 16-bit data, and held off until it has settled. STEP waits for the single-instruction cycle to complete before the requester gets a done/status response.

## Interface
Parameters:
- HOLDOFF, 4: settle cycles after every strobe; legal range ≥1.
- TIMEOUT, 1000000: maximum cycles spent waiting for STEP completion (only with timeout feature compiled in).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- p_valid / h_valid  in  1  panel / host command request.
- p_ready / h_ready  out  1  command accepted this cycle.
- p_cmd / h_cmd  in  4  command code.
- p_data / h_data  in  16  command operand.
- p_done / h_done  out  1  one-cycle completion pulse.
- p_status / h_status  out  2  result; valid only while done is high.
- stopped  in  1  CPU halted in monitor, from CPU control.
- b_step, b_reset, b_runhalt, b_storeinc, b_irq, b_dec, b_load, b_toA, b_toSP, b_toX, b_toY, b_toPC  out  1 each  one-hot command strobes.
- userInput  out  16  operand to CPU control.
- inputValid  out  1  operand qualifier, high with data-carrying strobes.
- busy  out  1  state ≠ IDLE.

## Operation
- Command codes: 0 NOP, 1 STEP, 2 RUNHALT, 3 RESET, 4 STOREINC, 5 DEC, 6 LOAD, 7 IRQ, 8 TOA, 9 TOX, 10 TOY, 11 TOPC, 12 TOSP, 13–15 illegal.
- Status codes: 0 OK, 1 REJ_RUNNING, 2 REJ_ILLEGAL, 3 TIMEOUT.
- Arbitration in IDLE only:
  - With a single valid requester, that requester is granted.
  - With both valid, the round-robin pointer decides. The pointer toggles to the other requester after every grant; reset value favours the panel.
  - ready is combinational: IDLE & grant & valid. cmd/data are latched on accept.
- Stop-gated commands are STEP, RESET, STOREINC, DEC, LOAD, TOA, TOX, TOY, TOPC and TOSP. They are rejected with REJ_RUNNING when stopped=0, sampled in the ISSUE cycle.
- Always-legal commands are RUNHALT, IRQ and NOP.
- NOP and rejected commands produce no strobe and go straight to DONE.
- inputValid is asserted together with the strobe for STOREINC, LOAD and TOA..TOSP; it is low for all other commands.
- userInput updates at ISSUE and holds its value until the next ISSUE.
- State machine:
  - IDLE → ISSUE on accept.
  - ISSUE: emit strobe (or reject). Go to HOLD, or to DONE if nothing was issued.
  - HOLD: count HOLDOFF cycles, then go to DONE; for STEP, go to STEP_LEAVE instead.
  - STEP_LEAVE: wait for stopped=0.
  - STEP_RETURN: wait for stopped=1, then go to DONE with OK.
  - DONE: one-cycle done pulse plus status to the granted requester, then back to IDLE.
- STEP_LEAVE already sees stopped=1 again on entry (no low observed): it stays in STEP_LEAVE. Completion requires an observed low then high.

## Timing
- Reset values: all outputs 0, state IDLE, pointer = panel, counters 0.
- rst asserted mid-operation aborts immediately: no done pulse, strobes drop that cycle.
- Non-STEP latency, with accept at cycle N:
  - strobe at N+1;
  - HOLD occupies N+2 .. N+1+HOLDOFF;
  - done at N+2+HOLDOFF;
  - next accept possible at N+3+HOLDOFF.
- Rejected or NOP command: done at N+2.
- At most one strobe is high in any cycle; every strobe lasts exactly one cycle.
- Requesters must hold valid/cmd/data until ready. done is never asserted in the same cycle as ready.
- The HOLDOFF counter width is $clog2(HOLDOFF+1).

## Configuration
- PANEL_CMD_TIMEOUT_EN defined:
  - A counter runs through STEP_LEAVE and STEP_RETURN combined.
  - When it reaches TIMEOUT cycles without completion, go to DONE with status TIMEOUT.
- PANEL_CMD_TIMEOUT_EN undefined:
  - STEP waits indefinitely and no timeout counter is built.
  - Status 3 is never produced.

## Structure
- Shared package quokka_panel_pkg holds:
  - the 4-bit command enum;
  - the 2-bit status enum;
  - the stop-gated-command and data-carrying-command predicates.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with grant outputs and a pointer toggled on accept.
- Command decode and the FSM stay in panel_cmd_sched.

## Test plan
- stopped=1; panel sends LOAD with data 0x1234 at cycle N → b_load and inputValid high at N+1 only, userInput=0x1234; p_done with OK at N+6 (HOLDOFF=4).
- stopped=0; host sends TOA → no strobe; h_done with REJ_RUNNING at N+2.
- Both valid from reset with STOREINC (panel) and IRQ (host) → panel granted first, host second; pointer then favours panel again; exactly two strobes.
- stopped=1; STEP; model drops stopped 2 cycles after b_step and raises it 30 cycles later → done with OK in the cycle after stopped rises.
- With PANEL_CMD_TIMEOUT_EN and TIMEOUT=100: STEP, stopped never returns → status TIMEOUT exactly 100 cycles after entering STEP_LEAVE. Without the macro: busy stays high.
- rst pulsed during HOLD → all outputs 0 next cycle, no done pulse; cmd code 14 → REJ_ILLEGAL with no strobe.
